// File: rtl/mac_array_pkg.sv
// Shared types and constants for the systolic MAC array sequencer.
package mac_array_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLR    = 3'd1,
    LOAD   = 3'd2,
    SETTLE = 3'd3,
    EXEC   = 3'd4,
    DRAIN  = 3'd5
  } state_e;

  localparam logic [1:0] INST_NOP  = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  // Instruction code the array sees while the sequencer sits in a state.
  function automatic logic [1:0] state_inst(input state_e s);
    logic [1:0] code;
    case (s)
      LOAD:    code = INST_LOAD;
      EXEC:    code = INST_EXEC;
      default: code = INST_NOP;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/mac_array_ctrl_inst_skew.sv
// Lane delay chain: lane l carries in_i delayed by l+1 cycles.
module inst_skew #(
  parameter int LANES = 8,
  parameter int WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       in_i,
  output logic [LANES*WIDTH-1:0] lanes_o
);

  logic [LANES*WIDTH-1:0] chain_q;

  // Shift every lane value one lane further down the chain each cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain_q <= '0;
    end else begin
      chain_q[WIDTH-1:0] <= in_i;
      for (int l = 1; l < LANES; l++) begin
        chain_q[l*WIDTH +: WIDTH] <= chain_q[(l-1)*WIDTH +: WIDTH];
      end
    end
  end

  assign lanes_o = chain_q;

endmodule

// File: rtl/mac_array_ctrl.sv
// Job sequencer for the row x col systolic MAC array: weight load,
// activation streaming, drain, skewed instruction lanes and psum strobes.
module mac_array_ctrl
  import mac_array_pkg::*;
#(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int addr_bw = 8,
  parameter int cnt_bw  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [cnt_bw-1:0]  num_vec,
  input  logic [addr_bw-1:0] w_base,
  input  logic [addr_bw-1:0] x_base,
  output logic               busy,
  output logic               done,
  output logic               array_rst,
  output logic               rd_en,
  output logic [addr_bw-1:0] rd_addr,
  output logic [2*row-1:0]   inst_w,
  output logic [col-1:0]     out_valid
);

  // Down-counter must hold the longest phase: num_vec-1 or row+col-1.
  localparam int CW = (cnt_bw > $clog2(row + col)) ? cnt_bw : $clog2(row + col);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [cnt_bw-1:0]  nv_q, nv_d;
  logic [addr_bw-1:0] wb_q, wb_d;
  logic [addr_bw-1:0] xb_q, xb_d;
  logic [addr_bw-1:0] rd_addr_q, rd_addr_d;
  logic               busy_q, done_q, arst_q, rd_en_q;
  logic               busy_d, done_d, arst_d, rd_en_d;
  logic               last_s;
  logic [1:0]         inst_code_s;

  assign last_s      = (cnt_q == '0);
  assign inst_code_s = state_inst(state_q);

  // Next-state, phase counter reload and registered-output decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    nv_d      = nv_q;
    wb_d      = wb_q;
    xb_d      = xb_q;
    rd_addr_d = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLR;
          nv_d    = num_vec;
          wb_d    = w_base;
          xb_d    = x_base;
        end else begin
          state_d = IDLE;
        end
      end
      CLR: begin
        state_d   = LOAD;
        cnt_d     = CW'(col - 1);
        rd_addr_d = wb_q;
      end
      LOAD: begin
        if (last_s) begin
          state_d = SETTLE;
          cnt_d   = CW'(row - 1);
        end else begin
          cnt_d     = cnt_q - CW'(1);
          rd_addr_d = rd_addr_q + addr_bw'(1);
        end
      end
      SETTLE: begin
        if (last_s) begin
          if (nv_q == '0) begin
            state_d = DRAIN;
            cnt_d   = CW'(row + col - 1);
          end else begin
            state_d   = EXEC;
            cnt_d     = CW'(nv_q) - CW'(1);
            rd_addr_d = xb_q;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      EXEC: begin
        if (last_s) begin
          state_d = DRAIN;
          cnt_d   = CW'(row + col - 1);
        end else begin
          cnt_d     = cnt_q - CW'(1);
          rd_addr_d = rd_addr_q + addr_bw'(1);
        end
      end
      DRAIN: begin
        if (last_s) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d  = (state_d != IDLE);
    done_d  = (state_q == DRAIN) && last_s;
    arst_d  = (state_d == CLR);
    rd_en_d = (state_d == LOAD) || (state_d == EXEC);
  end

  // State, job parameters and outputs; reset aborts any job silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      nv_q      <= '0;
      wb_q      <= '0;
      xb_q      <= '0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      arst_q    <= 1'b0;
      rd_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      nv_q      <= nv_d;
      wb_q      <= wb_d;
      xb_q      <= xb_d;
      rd_addr_q <= rd_addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      arst_q    <= arst_d;
      rd_en_q   <= rd_en_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign array_rst = arst_q;
  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;

  // Row lanes: lane 0 lines the code up with SRAM data, lane r adds r cycles.
  inst_skew #(.LANES(row), .WIDTH(2)) u_inst_skew (
    .clk    (clk),
    .reset  (reset),
    .in_i   (inst_code_s),
    .lanes_o(inst_w)
  );

  // Execute bit leaving the last row feeds the column-skewed psum strobes.
  inst_skew #(.LANES(col), .WIDTH(1)) u_valid_skew (
    .clk    (clk),
    .reset  (reset),
    .in_i   (inst_w[2*row-1]),
    .lanes_o(out_valid)
  );

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Self-checking bench for mac_array_ctrl (row = col = 4) against a job-offset model.
module tb_mac_array_ctrl;

  localparam int ROW = 4;
  localparam int COL = 4;
  localparam int AW  = 8;
  localparam int CB  = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [CB-1:0]   num_vec;
  logic [AW-1:0]   w_base;
  logic [AW-1:0]   x_base;
  logic            busy;
  logic            done;
  logic            array_rst;
  logic            rd_en;
  logic [AW-1:0]   rd_addr;
  logic [2*ROW-1:0] inst_w;
  logic [COL-1:0]  out_valid;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [1:0] hist [0:4095];

  // Model of the current job: k = cycles since start edge (1 = CLR cycle).
  int         k     = 0;
  int         t_job = 0;
  int         m_nv  = 0;
  logic [7:0] m_wb  = 8'h00;
  logic [7:0] m_xb  = 8'h00;
  int         lat;

  mac_array_ctrl #(.row(ROW), .col(COL), .addr_bw(AW), .cnt_bw(CB)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .num_vec  (num_vec),
    .w_base   (w_base),
    .x_base   (x_base),
    .busy     (busy),
    .done     (done),
    .array_rst(array_rst),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .inst_w   (inst_w),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_all();
    logic             active;
    logic             in_load;
    logic             in_exec;
    logic [1:0]       code;
    logic [7:0]       exp_addr;
    logic [2*ROW-1:0] exp_inst;
    logic [COL-1:0]   exp_ov;
    int               t0;
    int               idx;
    t0      = 2 + COL + ROW;
    active  = (k >= 1) && (k <= t_job);
    in_load = active && (k >= 2) && (k <= 1 + COL);
    in_exec = active && (k >= t0) && (k <= t0 + m_nv - 1);
    code    = in_load ? 2'b01 : (in_exec ? 2'b10 : 2'b00);
    hist[cyc] = code;
    exp_addr = 8'h00;
    if (in_load) exp_addr = m_wb + 8'(k - 2);
    if (in_exec) exp_addr = m_xb + 8'(k - t0);
    for (int r = 0; r < ROW; r++) begin
      idx = cyc - 1 - r;
      exp_inst[2*r +: 2] = (idx >= 0) ? hist[idx] : 2'b00;
    end
    for (int c = 0; c < COL; c++) begin
      exp_ov[c] = (t_job > 0) && (k >= t0 + 1 + ROW + c) && (k <= t0 + ROW + c + m_nv);
    end
    chk("busy", 32'(busy), 32'(active));
    chk("done", 32'(done), 32'((t_job > 0) && (k == t_job + 1)));
    chk("array_rst", 32'(array_rst), 32'(active && (k == 1)));
    chk("rd_en", 32'(rd_en), 32'(in_load || in_exec));
    if (in_load || in_exec) chk("rd_addr", 32'(rd_addr), 32'(exp_addr));
    chk("inst_w", 32'(inst_w), 32'(exp_inst));
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
  endtask

  task automatic step(input logic s, input int nv, input logic [7:0] wb, input logic [7:0] xb);
    start   = s;
    num_vec = 8'(nv);
    w_base  = wb;
    x_base  = xb;
    @(posedge clk);
    if (!((k >= 1) && (k <= t_job)) && s) begin
      k     = 1;
      t_job = 1 + COL + ROW + nv + ROW + COL;
      m_nv  = nv;
      m_wb  = wb;
      m_xb  = xb;
    end else if (k < 100000) begin
      k++;
    end
    #1;
    cyc++;
    check_all();
  endtask

  task automatic model_reset();
    k     = 0;
    t_job = 0;
    m_nv  = 0;
    for (int i = 0; i <= cyc; i++) hist[i] = 2'b00;
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    num_vec = 8'h00;
    w_base  = 8'h00;
    x_base  = 8'h00;
    for (int i = 0; i < 4096; i++) hist[i] = 2'b00;
    #2;
    check_all();
    @(posedge clk);
    #1;
    cyc++;
    check_all();
    reset = 1'b0;

    // Reset abort in the middle of EXEC.
    step(1'b1, 6, 8'h20, 8'h40);
    while (k < 2 + COL + ROW + 2) step(1'b0, 0, 8'h00, 8'h00);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_array_rst", 32'(array_rst), 32'd0);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_inst_w", 32'(inst_w), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      check_all();
    end
    reset = 1'b0;
    for (int i = 0; i < 6; i++) step(1'b0, 0, 8'h00, 8'h00);

    // Directed job: weight addresses wrap FE, FF, 00, 01 then 10, 11, 12.
    step(1'b1, 3, 8'hFE, 8'h10);
    lat = 1;
    step(1'b0, 0, 8'h00, 8'h00);
    while (done !== 1'b1 && lat < 200) begin
      lat++;
      step(1'b0, 0, 8'h00, 8'h00);
    end
    chk("done_latency_nv3", 32'(lat), 32'd20);
    for (int i = 0; i < 3; i++) step(1'b0, 0, 8'h00, 8'h00);

    // Zero activation vectors: no EXEC phase.
    step(1'b1, 0, 8'h33, 8'h77);
    lat = 1;
    step(1'b0, 0, 8'h00, 8'h00);
    while (done !== 1'b1 && lat < 200) begin
      lat++;
      step(1'b0, 0, 8'h00, 8'h00);
    end
    chk("done_latency_nv0", 32'(lat), 32'd17);
    for (int i = 0; i < 3; i++) step(1'b0, 0, 8'h00, 8'h00);

    // Start held high: back-to-back jobs, changing inputs while busy are ignored.
    for (int i = 0; i < 80; i++) begin
      step(1'b1, 2 + (i % 3), 8'($urandom), 8'($urandom));
    end
    for (int i = 0; i < 30; i++) step(1'b0, 0, 8'h00, 8'h00);

    // Randomised start pulses and job parameters.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 7) == 0), int'($urandom_range(0, 10)),
           8'($urandom), 8'($urandom));
    end
    for (int i = 0; i < 40; i++) step(1'b0, 0, 8'h00, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
